// File: rtl/jt51_op_acc.sv
// Stereo frame accumulator for the time-multiplexed operator bus: sums carrier
// slots over a 32-slot frame, saturates and outputs one sample per frame.
// Optional sticky overflow flag port enabled with `define JT51_ACC_OVF_EN.
module jt51_op_acc #(
  parameter int W_ACC = 19,
  parameter int W_OUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             zero,
  input  logic [13:0]      op_in,
  input  logic [2:0]       con,
  input  logic [1:0]       rl,
  output logic [W_OUT-1:0] left,
  output logic [W_OUT-1:0] right,
  output logic             sample
`ifdef JT51_ACC_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic {SYNC, RUN} state_t;

  state_t            state, state_nxt;
  logic [4:0]        cnt, slot;
  logic              active, carrier;
  logic [W_ACC-1:0]  op_ext, add_l, add_r, sum_l, sum_r, acc_l, acc_r;
  logic [W_OUT-1:0]  sat_l, sat_r;

  // True when the value is representable in W_OUT signed bits.
  function automatic logic fits(input logic [W_ACC-1:0] v);
    return v[W_ACC-1:W_OUT-1] == {(W_ACC-W_OUT+1){v[W_ACC-1]}};
  endfunction

  function automatic logic [W_OUT-1:0] saturate(input logic [W_ACC-1:0] v);
    if (fits(v))
      return v[W_OUT-1:0];
    else if (v[W_ACC-1])
      return {1'b1, {(W_OUT-1){1'b0}}};
    else
      return {1'b0, {(W_OUT-1){1'b1}}};
  endfunction

  // A zero marker always restarts the frame, whatever the counter says.
  always_comb begin
    state_nxt = state;
    active    = 1'b0;
    slot      = cnt;
    if (cen) begin
      case (state)
        SYNC: if (zero) begin
          state_nxt = RUN;
          active    = 1'b1;
          slot      = 5'd0;
        end
        RUN: begin
          active = 1'b1;
          if (zero) slot = 5'd0;
        end
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_comb begin
    case (slot[4:3])
      2'd0:    carrier = (con == 3'd7);
      2'd1:    carrier = (con >= 3'd5);
      2'd2:    carrier = (con >= 3'd4);
      default: carrier = 1'b1;
    endcase
  end

  always_comb begin
    op_ext = {{(W_ACC-14){op_in[13]}}, op_in};
    add_l  = (carrier && rl[1]) ? op_ext : '0;
    add_r  = (carrier && rl[0]) ? op_ext : '0;
    sum_l  = (slot == 5'd0) ? add_l : acc_l + add_l;
    sum_r  = (slot == 5'd0) ? add_r : acc_r + add_r;
    sat_l  = saturate(sum_l);
    sat_r  = saturate(sum_r);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= SYNC;
      cnt    <= 5'd0;
      acc_l  <= '0;
      acc_r  <= '0;
      left   <= '0;
      right  <= '0;
      sample <= 1'b0;
    end else begin
      state  <= state_nxt;
      sample <= 1'b0;
      if (active) begin
        cnt   <= slot + 5'd1;
        acc_l <= sum_l;
        acc_r <= sum_r;
        if (slot == 5'd31) begin
          left   <= sat_l;
          right  <= sat_r;
          sample <= 1'b1;
        end
      end
    end
  end

`ifdef JT51_ACC_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ovf <= 1'b0;
    else if (active && slot == 5'd31 && (!fits(sum_l) || !fits(sum_r)))
      ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_jt51_op_acc.sv
// Randomised self-checking bench for jt51_op_acc against a frame-level model.
// Build with +define+JT51_ACC_OVF_EN to also check the overflow flag.
module tb_jt51_op_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen, zero;
  logic [13:0] op_in;
  logic [2:0]  con;
  logic [1:0]  rl;
  logic [15:0] left, right;
  logic        sample;
`ifdef JT51_ACC_OVF_EN
  logic        ovf;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model state: whole frame stored, summed when slot 31 arrives.
  bit synced = 0;
  int idx    = 0;
  int fr_op[32];
  int fr_con[32];
  int fr_rl[32];
  int exp_l = 0, exp_r = 0;
  bit exp_sample = 0;
  bit exp_ovf    = 0;

  jt51_op_acc #(.W_ACC(19), .W_OUT(16)) dut (
    .clk(clk), .rst(rst), .cen(cen), .zero(zero), .op_in(op_in),
    .con(con), .rl(rl), .left(left), .right(right), .sample(sample)
`ifdef JT51_ACC_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit is_carrier(input int grp, input int cn);
    case (grp)
      0:       return cn == 7;
      1:       return cn == 5 || cn == 6 || cn == 7;
      2:       return cn >= 4;
      default: return 1;
    endcase
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic finish_frame();
    int sl = 0, sr = 0;
    for (int s = 0; s < 32; s++) begin
      if (is_carrier(s / 8, fr_con[s])) begin
        if (fr_rl[s] >= 2) sl += fr_op[s];
        if (fr_rl[s] % 2 == 1) sr += fr_op[s];
      end
    end
    exp_l = clamp(sl);
    exp_r = clamp(sr);
    if (exp_l != sl || exp_r != sr) exp_ovf = 1;
    exp_sample = 1;
  endtask

  // One clk cycle: drive, advance the model, compare after the edge.
  task automatic step(input bit c, input bit z, input int op, input int cn, input int r);
    @(negedge clk);
    cen = c; zero = z; op_in = op[13:0]; con = cn[2:0]; rl = r[1:0];
    exp_sample = 0;
    if (c) begin
      if (z) begin
        synced = 1;
        idx = 0;
      end
      if (synced) begin
        fr_op[idx] = op; fr_con[idx] = cn; fr_rl[idx] = r;
        if (idx == 31) finish_frame();
        idx = (idx + 1) % 32;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("left",   int'($signed(left)),  exp_l);
    checkOutput("right",  int'($signed(right)), exp_r);
    checkOutput("sample", int'(sample),         int'(exp_sample));
`ifdef JT51_ACC_OVF_EN
    checkOutput("ovf",    int'(ovf),            int'(exp_ovf));
`endif
  endtask

  function automatic int rnd_op();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic idle_maybe();
    if ($urandom_range(0, 3) == 0)
      step(0, $urandom_range(0, 1), rnd_op(), $urandom_range(0, 7), $urandom_range(0, 3));
  endtask

  // n slots with constant con/rl/op (or random per slot when rnd is set).
  task automatic applyStimulus(input bit with_zero, input int n, input int cn, input int r,
                               input int op, input bit rnd);
    for (int s = 0; s < n; s++) begin
      idle_maybe();
      if (rnd) step(1, with_zero && s == 0, rnd_op(), $urandom_range(0, 7), $urandom_range(0, 3));
      else     step(1, with_zero && s == 0, op, cn, r);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    synced = 0; idx = 0; exp_l = 0; exp_r = 0; exp_sample = 0; exp_ovf = 0;
    checkOutput("rst_left",   int'($signed(left)),  0);
    checkOutput("rst_right",  int'($signed(right)), 0);
    checkOutput("rst_sample", int'(sample),         0);
`ifdef JT51_ACC_OVF_EN
    checkOutput("rst_ovf",    int'(ovf),            0);
`endif
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; cen = 0; zero = 0; op_in = '0; con = '0; rl = '0;
    repeat (2) @(negedge clk);
    checkOutput("por_left",   int'($signed(left)),  0);
    checkOutput("por_right",  int'($signed(right)), 0);
    checkOutput("por_sample", int'(sample),         0);
    rst = 1'b1;

    // Nothing happens in SYNC before the first zero marker.
    applyStimulus(0, 40, 7, 3, 100, 0);

    applyStimulus(1, 32, 7, 3, 100, 0);
    checkOutput("lit_all_left",  int'($signed(left)),  3200);
    checkOutput("lit_all_right", int'($signed(right)), 3200);

    applyStimulus(0, 32, 0, 2, 1000, 0);
    checkOutput("lit_c2_left",  int'($signed(left)),  8000);
    checkOutput("lit_c2_right", int'($signed(right)), 0);

    applyStimulus(0, 32, 7, 3, 8191, 0);
    checkOutput("lit_pos_sat", int'(left), 32'h7FFF);
    applyStimulus(0, 32, 7, 3, 0, 0);
    checkOutput("lit_quiet", int'($signed(left)), 0);
`ifdef JT51_ACC_OVF_EN
    checkOutput("lit_ovf_sticky", int'(ovf), 1);
`endif

    applyStimulus(0, 32, 7, 3, -8192, 0);
    checkOutput("lit_neg_sat", int'(left), 32'h8000);
    applyStimulus(0, 32, 7, 3, 0, 0);
    checkOutput("lit_neg_zero", int'($signed(left)), 0);

    // Resync part way through a frame: the truncated frame never emits.
    applyStimulus(0, 12, 7, 3, 500, 0);
    applyStimulus(1, 32, 7, 3, 100, 0);
    checkOutput("lit_resync", int'($signed(left)), 3200);

    for (int f = 0; f < 12; f++) begin
      applyStimulus(0, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 31)) : 32, 0, 0, 0, 1);
    end
    applyStimulus(1, 32, 0, 0, 0, 1);
    for (int f = 0; f < 6; f++) applyStimulus(0, 32, 0, 0, 0, 1);

    applyStimulus(0, 32, 7, 3, 100, 0);
    applyStimulus(0, 10, 7, 3, 100, 0);
    async_reset();
    applyStimulus(0, 40, 7, 3, 300, 0);
    applyStimulus(1, 32, 0, 2, 1000, 0);
    checkOutput("lit_after_rst", int'($signed(left)), 8000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
